// File: rtl/snoop_bus_arbiter_pkg.sv
// Coherence definitions shared with the cache controllers: bus op and snoop
// response encodings, plus the snoop-bus arbiter state encoding.
package cache_def;

  localparam int unsigned STATE_WIDTH = 3;

  typedef enum logic [1:0] {
    NO_REQ   = 2'd0,
    BUS_RD   = 2'd1,
    BUS_RDX  = 2'd2,
    BUS_UPGR = 2'd3
  } bus_op_e;

  typedef enum logic [1:0] {
    NO_RSP = 2'd0,
    SHARED = 2'd1,
    FLUSH  = 2'd2
  } snp_rsp_e;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_WB    = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus bundle between the cache controllers, memory and the bus arbiter.
// The master modport is the arbiter; slave is the cache/memory side.
interface snoop_bus_arbiter_if #(
  parameter int unsigned NUM_CACHE   = 4,
  parameter int unsigned LADDR_WIDTH = 58
);
  localparam int unsigned IDX_W = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;

  logic [NUM_CACHE-1:0]             req;
  logic [2*NUM_CACHE-1:0]           req_type;
  logic [LADDR_WIDTH*NUM_CACHE-1:0] req_addr;
  logic [NUM_CACHE-1:0]             gnt;
  logic [1:0]                       bus_req;
  logic [LADDR_WIDTH-1:0]           bus_addr;
  logic [IDX_W-1:0]                 bus_src;
  logic [2*NUM_CACHE-1:0]           snp_rsp;
  logic [NUM_CACHE-1:0]             snp_wb;
  logic                             mem_rd;
  logic                             mem_wr;
  logic                             mem_ack;
  logic                             done;
  logic                             shared;
  logic                             err;

  modport master (
    input  req, req_type, req_addr, snp_rsp, snp_wb, mem_ack,
    output gnt, bus_req, bus_addr, bus_src, mem_rd, mem_wr, done, shared, err
  );

  modport slave (
    output req, req_type, req_addr, snp_rsp, snp_wb, mem_ack,
    input  gnt, bus_req, bus_addr, bus_src, mem_rd, mem_wr, done, shared, err
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_CACHE = 4,
  parameter int unsigned IDX_W     = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1
) (
  input  logic [NUM_CACHE-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CACHE-1:0] gnt_c
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CACHE; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_CACHE);
      if (!found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one cache at a time, runs the snoop phase, then an
// optional write-back and memory read before signalling completion.
module snoop_bus_arbiter
  import cache_def::*;
#(
  parameter int unsigned NUM_CACHE   = 4,
  parameter int unsigned LADDR_WIDTH = 58,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  snoop_bus_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  arb_state_e             state_q;
  logic [NUM_CACHE-1:0]   gnt_q;
  bus_op_e                op_q;
  logic [LADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]       src_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rsp_shared_q;
  logic                   flush_q;
  logic                   mem_rd_q;
  logic                   mem_wr_q;
  logic                   done_q;
  logic                   shared_q;
  logic                   err_q;

  logic [NUM_CACHE-1:0]   req_vld_c;
  logic [NUM_CACHE-1:0]   arb_gnt_c;
  logic [IDX_W-1:0]       win_idx_c;
  bus_op_e                win_op_c;
  logic [LADDR_WIDTH-1:0] win_addr_c;
  logic                   snp_any_c;
  logic                   snp_flush_c;
  logic                   snp_wb_c;

  always_comb begin
    req_vld_c = '0;
    for (int unsigned i = 0; i < NUM_CACHE; i++) begin
      req_vld_c[i] = bus.req[i] && (bus.req_type[2*i +: 2] != NO_REQ);
    end
  end

  rr_arbiter #(.NUM_CACHE(NUM_CACHE), .IDX_W(IDX_W)) u_rr_arbiter (
    .req   (req_vld_c),
    .ptr   (rr_ptr_q),
    .gnt_c (arb_gnt_c)
  );

  // One-hot winner to index, op and address.
  always_comb begin
    win_idx_c  = '0;
    win_op_c   = NO_REQ;
    win_addr_c = '0;
    for (int unsigned i = 0; i < NUM_CACHE; i++) begin
      if (arb_gnt_c[i]) begin
        win_idx_c  = IDX_W'(i);
        win_op_c   = bus_op_e'(bus.req_type[2*i +: 2]);
        win_addr_c = bus.req_addr[LADDR_WIDTH*i +: LADDR_WIDTH];
      end
    end
  end

  // Snoop responses from every cache except the current owner.
  always_comb begin
    snp_any_c   = 1'b0;
    snp_flush_c = 1'b0;
    snp_wb_c    = 1'b0;
    for (int unsigned i = 0; i < NUM_CACHE; i++) begin
      if (!gnt_q[i]) begin
        snp_any_c   = snp_any_c   | (bus.snp_rsp[2*i +: 2] != NO_RSP);
        snp_flush_c = snp_flush_c | (bus.snp_rsp[2*i +: 2] == FLUSH);
        snp_wb_c    = snp_wb_c    | bus.snp_wb[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      op_q         <= NO_REQ;
      addr_q       <= '0;
      src_q        <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rsp_shared_q <= 1'b0;
      flush_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      done_q       <= 1'b0;
      shared_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_vld_c) begin
            state_q <= ST_SNOOP;
            gnt_q   <= arb_gnt_c;
            op_q    <= win_op_c;
            addr_q  <= win_addr_c;
            src_q   <= win_idx_c;
          end
        end
        ST_SNOOP: begin
          rsp_shared_q <= snp_any_c;
          flush_q      <= snp_flush_c;
          cnt_q        <= '0;
          if (snp_wb_c) begin
            state_q  <= ST_WB;
            mem_wr_q <= 1'b1;
          end else if (op_q == BUS_UPGR || snp_flush_c) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            shared_q <= snp_any_c;
          end else begin
            state_q  <= ST_MEM;
            mem_rd_q <= 1'b1;
          end
        end
        ST_WB, ST_MEM: begin
          if (bus.mem_ack) begin
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            cnt_q    <= '0;
            // A write-back still needs the line from memory unless a peer flushed it.
            if (state_q == ST_WB && !(op_q == BUS_UPGR || flush_q)) begin
              state_q  <= ST_MEM;
              mem_rd_q <= 1'b1;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              shared_q <= rsp_shared_q;
            end
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            shared_q <= rsp_shared_q;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          gnt_q    <= '0;
          op_q     <= NO_REQ;
          done_q   <= 1'b0;
          shared_q <= 1'b0;
          err_q    <= 1'b0;
          rr_ptr_q <= IDX_W'((32'(src_q) + 32'd1) % NUM_CACHE);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.bus_req  = op_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_src  = src_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.done     = done_q;
  assign bus.shared   = shared_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: basic read, round-robin order,
// write-back with flush, upgrade with sharers, memory timeout, mid-flight reset.
module tb_snoop_bus_arbiter;
  import cache_def::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   rd_cycles;

  snoop_bus_arbiter_if #(.NUM_CACHE(4), .LADDR_WIDTH(58)) bus ();

  snoop_bus_arbiter #(.NUM_CACHE(4), .LADDR_WIDTH(58), .MEM_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic [1:0] t, input logic [57:0] a);
    bus.req[c]             = 1'b1;
    bus.req_type[2*c +: 2] = t;
    bus.req_addr[58*c +: 58] = a;
  endtask

  task automatic clr_req(input int c);
    bus.req[c]             = 1'b0;
    bus.req_type[2*c +: 2] = 2'd0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rd_cycles    = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_type = '0;
    bus.req_addr = '0;
    bus.snp_rsp  = '0;
    bus.snp_wb   = '0;
    bus.mem_ack  = 1'b0;
    tick();
    tick();
    chk("rst_gnt",     64'(bus.gnt),      64'h0);
    chk("rst_bus_req", 64'(bus.bus_req),  64'h0);
    chk("rst_mem_rd",  64'(bus.mem_rd),   64'h0);
    chk("rst_done",    64'(bus.done),     64'h0);
    chk("rst_err",     64'(bus.err),      64'h0);
    rst_n = 1'b1;

    // Cache0 BUS_RD 0x10, no snoop hit, ack in third memory cycle
    set_req(0, BUS_RD, 58'h10);
    tick();
    chk("rd_gnt",      64'(bus.gnt),      64'h1);
    chk("rd_bus_req",  64'(bus.bus_req),  64'h1);
    chk("rd_bus_addr", 64'(bus.bus_addr), 64'h10);
    chk("rd_bus_src",  64'(bus.bus_src),  64'h0);
    chk("rd_snoop_no_mem", 64'(bus.mem_rd), 64'h0);
    tick();
    chk("rd_mem_c1",   64'(bus.mem_rd),   64'h1);
    chk("rd_no_wr",    64'(bus.mem_wr),   64'h0);
    tick();
    chk("rd_mem_c2",   64'(bus.mem_rd),   64'h1);
    tick();
    chk("rd_mem_c3",   64'(bus.mem_rd),   64'h1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("rd_done",     64'(bus.done),     64'h1);
    chk("rd_shared",   64'(bus.shared),   64'h0);
    chk("rd_err",      64'(bus.err),      64'h0);
    chk("rd_mem_off",  64'(bus.mem_rd),   64'h0);
    clr_req(0);
    tick();
    chk("rd_done_pulse", 64'(bus.done),   64'h0);
    chk("rd_gnt_off",  64'(bus.gnt),      64'h0);
    chk("rd_idle_req", 64'(bus.bus_req),  64'h0);

    // Round-robin from a fresh pointer: caches 0 and 2 together
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, BUS_UPGR, 58'h100);
    set_req(2, BUS_UPGR, 58'h200);
    tick();
    chk("rr_first",    64'(bus.gnt),      64'h1);
    tick();
    chk("rr_first_done", 64'(bus.done),   64'h1);
    clr_req(0);
    tick();
    chk("rr_gap",      64'(bus.gnt),      64'h0);
    tick();
    chk("rr_second",   64'(bus.gnt),      64'h4);
    chk("rr_second_addr", 64'(bus.bus_addr), 64'h200);
    chk("rr_second_src",  64'(bus.bus_src),  64'h2);
    tick();
    chk("rr_second_done", 64'(bus.done),  64'h1);
    clr_req(2);
    tick();
    // Pointer now 3: lone cache0 request wraps around
    set_req(0, BUS_UPGR, 58'h300);
    tick();
    chk("rr_wrap",     64'(bus.gnt),      64'h1);
    tick();
    clr_req(0);
    tick();
    // Pointer now 1: caches 0 and 1 -> cache1 first
    set_req(0, BUS_UPGR, 58'h310);
    set_req(1, BUS_UPGR, 58'h400);
    tick();
    chk("rr_ptr1",     64'(bus.gnt),      64'h2);
    tick();
    clr_req(1);
    tick();
    tick();
    chk("rr_then0",    64'(bus.gnt),      64'h1);
    tick();
    clr_req(0);
    tick();

    // Pointer 1: cache1 BUS_RDX, cache3 write-back and flush
    set_req(1, BUS_RDX, 58'h55);
    tick();
    chk("wb_gnt",      64'(bus.gnt),      64'h2);
    chk("wb_bus_req",  64'(bus.bus_req),  64'h2);
    bus.snp_rsp[7:6] = 2'd2;
    bus.snp_wb[3]    = 1'b1;
    tick();
    bus.snp_rsp = '0;
    bus.snp_wb  = '0;
    chk("wb_wr_c1",    64'(bus.mem_wr),   64'h1);
    chk("wb_no_rd_c1", 64'(bus.mem_rd),   64'h0);
    tick();
    chk("wb_wr_c2",    64'(bus.mem_wr),   64'h1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("wb_done",     64'(bus.done),     64'h1);
    chk("wb_no_rd",    64'(bus.mem_rd),   64'h0);
    chk("wb_wr_off",   64'(bus.mem_wr),   64'h0);
    chk("wb_shared",   64'(bus.shared),   64'h1);
    clr_req(1);
    tick();

    // Pointer 2: cache2 BUS_UPGR, cache0 SHARED; owner's own responses ignored
    set_req(2, BUS_UPGR, 58'habc);
    tick();
    chk("up_gnt",      64'(bus.gnt),      64'h4);
    bus.snp_rsp[1:0] = 2'd1;
    bus.snp_rsp[5:4] = 2'd2;
    bus.snp_wb[2]    = 1'b1;
    tick();
    bus.snp_rsp = '0;
    bus.snp_wb  = '0;
    chk("up_done",     64'(bus.done),     64'h1);
    chk("up_shared",   64'(bus.shared),   64'h1);
    chk("up_no_wr",    64'(bus.mem_wr),   64'h0);
    chk("up_no_rd",    64'(bus.mem_rd),   64'h0);
    chk("up_err",      64'(bus.err),      64'h0);
    clr_req(2);
    tick();

    // Pointer 3: cache3 BUS_RD, memory never acknowledges
    set_req(3, BUS_RD, 58'h3ff);
    tick();
    chk("to_gnt",      64'(bus.gnt),      64'h8);
    for (int k = 0; k < 64; k++) begin
      tick();
      if (bus.mem_rd === 1'b1) rd_cycles++;
    end
    chk("to_rd_cycles", 64'(rd_cycles),   64'd64);
    chk("to_no_done_yet", 64'(bus.done),  64'h0);
    tick();
    chk("to_done",     64'(bus.done),     64'h1);
    chk("to_err",      64'(bus.err),      64'h1);
    chk("to_rd_off",   64'(bus.mem_rd),   64'h0);
    clr_req(3);
    tick();
    chk("to_err_clr",  64'(bus.err),      64'h0);

    // Pointer 0: reset during MEM aborts with no done
    set_req(0, BUS_RD, 58'h77);
    tick();
    tick();
    chk("rs_in_mem",   64'(bus.mem_rd),   64'h1);
    rst_n = 1'b0;
    tick();
    chk("rs_gnt",      64'(bus.gnt),      64'h0);
    chk("rs_mem_rd",   64'(bus.mem_rd),   64'h0);
    chk("rs_bus_req",  64'(bus.bus_req),  64'h0);
    chk("rs_bus_addr", 64'(bus.bus_addr), 64'h0);
    chk("rs_done",     64'(bus.done),     64'h0);
    rst_n = 1'b1;
    clr_req(0);
    tick();
    chk("rs_no_done",  64'(bus.done),     64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 Parameter: NUM_CACHE, 4, number of cache controllers sharing the snoop bus.
REQ-002 Parameter: LADDR_WIDTH, 58, line address width.
REQ-003 Parameter: MEM_TIMEOUT, 64, cycles allowed for mem_ack.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req  in  NUM_CACHE  per-cache bus request valid; held until done.
REQ-007 req_type  in  2*NUM_CACHE  per-cache op: 0 NO_REQ, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR.
REQ-008 req_addr  in  LADDR_WIDTH*NUM_CACHE  per-cache line address.
REQ-009 gnt  out  NUM_CACHE  one-hot bus ownership.
REQ-010 bus_req / bus_addr / bus_src  out  2 / LADDR_WIDTH / clog2(NUM_CACHE)  broadcast op, address, owner index.
REQ-011 snp_rsp  in  2*NUM_CACHE  per-cache snoop response: 0 NO_RSP, 1 SHARED, 2 FLUSH (data supplied).
REQ-012 snp_wb  in  NUM_CACHE  per-cache write-back request on snoop hit in MODIFIED.
REQ-013 mem_rd / mem_wr  out  1 / 1  memory read / write-back strobes; mem_ack  in  1  completion.
REQ-014 done / shared / err  out  1 / 1 / 1  transaction complete pulse, line held elsewhere, timeout.

Function
REQ-015 States: IDLE, SNOOP, WB, MEM, DONE; one transaction in flight.
REQ-016 IDLE: if any req with req_type!=0, grant round-robin winner next cycle, starting search at rr_ptr; enter SNOOP.
REQ-017 req with req_type==0 is ignored by arbitration.
REQ-018 On grant, latch winner's type/address; drive bus_req, bus_addr, bus_src from latch for whole transaction; bus_req=0 in IDLE.
REQ-019 SNOOP lasts exactly 1 cycle; snp_rsp/snp_wb of granted cache are ignored.
REQ-020 SNOOP: shared_q <= OR over non-owner snp_rsp!=0; flush_q <= OR of snp_rsp==2; wb_q <= OR of snp_wb.
REQ-021 SNOOP exit: wb_q -> WB; else type UPGR or flush -> DONE; else MEM.
REQ-022 WB: mem_wr=1 until mem_ack; then -> DONE if type UPGR or flush, else MEM.
REQ-023 MEM: mem_rd=1 until mem_ack; then -> DONE.
REQ-024 mem_ack outside WB/MEM ignored; mem_rd and mem_wr never both high.
REQ-025 Timeout counter clears on WB/MEM entry; at MEM_TIMEOUT cycles without ack -> DONE with err=1.
REQ-026 DONE: 1-cycle done=1, shared=shared_q, err per REQ-025; gnt deasserts on exit; -> IDLE.
REQ-027 rr_ptr <= (winner+1) mod NUM_CACHE on leaving DONE.
REQ-028 Minimum transaction: grant, SNOOP, DONE = 3 cycles; back-to-back grant earliest cycle after DONE.
REQ-029 Owner dropping req mid-transaction does not abort it.

Reset
REQ-030 rst_n low at clk edge: state IDLE, gnt=0, bus_req=0, bus_addr=0, bus_src=0, mem_rd=0, mem_wr=0, done=0, shared=0, err=0, rr_ptr=0, counter=0.
REQ-031 Reset mid-transaction aborts it; no done pulse.

Structure
REQ-032 Bus op and snoop response encodings, STATE_WIDTH shared package cache_def with cache controllers.
REQ-033 One sub-module: rr_arbiter (NUM_CACHE-wide round-robin, pointer input, one-hot output).

Verification
REQ-034 Cache0 BUS_RD 0x10, no snoop hit, mem_ack after 3 cycles -> gnt=0001, mem_rd 3 cycles, done with shared=0.
REQ-035 Caches 0,2 request same cycle, rr_ptr=0 -> cache0 then cache2; then cache0 and 1 requesting -> cache1 first.
REQ-036 Cache1 BUS_RDX, cache3 snp_wb=1, snp_rsp=2 -> WB then DONE, no mem_rd.
REQ-037 Cache2 BUS_UPGR, cache0 snp_rsp=1 -> done on 3rd cycle, shared=1, no mem strobes.
REQ-038 BUS_RD with mem_ack never asserted -> done and err=1 after 64 MEM cycles.
REQ-039 rst_n low during MEM -> all outputs zero next cycle, no done.
